// File: rtl/spu_arith_pkg.sv
// Shared definitions for the SPU arithmetic datapath cells.
// Handshake rule: a transfer happens on a rising edge where valid && ready are both high.
package spu_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: two cascaded half subtractors and an OR.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_d1;
  logic w_b1;
  logic w_b2;

  // First stage computes a-b; the second stage subtracts the incoming borrow.
  assign w_d1 = a ^ b;
  assign w_b1 = ~a & b;
  assign d    = w_d1 ^ bin;
  assign w_b2 = ~w_d1 & bin;
  assign bout = w_b1 | w_b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a-b LSB-first, one bit per clock,
// with valid/ready handshakes on both operand and result sides.
module serial_subtractor
  import spu_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_bw;
  logic             w_d;
  logic             w_bout;
  logic             w_accept;
  logic             w_last;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  full_subtractor u_fs (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_bw),
    .d    (w_d),
    .bout (w_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, so there is no input-to-output path.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_diff <= '0;
      r_bw   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sr <= a;
      r_b_sr <= b;
      r_bw   <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == RUN) begin
      r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
      // After WIDTH shifts the first result bit has reached the LSB.
      r_diff <= {w_d, r_diff[WIDTH-1:1]};
      r_bw   <= w_bout;
      if (!w_last) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign diff   = r_diff;
  assign borrow = r_bw;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed table, handshake corner cases and
// randomized operands at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel16;
  logic        iv;
  logic        ordy;
  logic [15:0] opa;
  logic [15:0] opb;

  logic        iv8, ir8, ov8, bw8;
  logic [7:0]  d8;
  logic        iv16, ir16, ov16, bw16;
  logic [15:0] d16;

  logic        ir;
  logic        ov;
  logic [16:0] res;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign iv8  = iv & ~sel16;
  assign iv16 = iv & sel16;
  assign ir   = sel16 ? ir16 : ir8;
  assign ov   = sel16 ? ov16 : ov8;
  assign res  = sel16 ? {bw16, d16} : {8'b0, bw8, d8};

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (opa[7:0]),
    .b         (opb[7:0]),
    .out_valid (ov8),
    .out_ready (ordy),
    .diff      (d8),
    .borrow    (bw8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (opa),
    .b         (opb),
    .out_valid (ov16),
    .out_ready (ordy),
    .diff      (d16),
    .borrow    (bw16)
  );

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bw;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input bit wide);
    logic [8:0]  r9;
    logic [16:0] r17;
    if (wide) begin
      r17 = {1'b0, a} - {1'b0, b};
      return r17;
    end
    r9 = {1'b0, a[7:0]} - {1'b0, b[7:0]};
    return {8'b0, r9};
  endfunction

  // Caller guarantees the selected DUT is idle; returns result and accept-to-valid latency.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int stall,
                        output logic [16:0] r, output int lat, output bit timeout);
    iv   = 1'b1;
    opa  = a;
    opb  = b;
    ordy = (stall == 0);
    @(posedge clk); #1;
    iv  = 1'b0;
    opa = $urandom;
    opb = $urandom;
    lat = 0;
    while (!ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    timeout = !ov;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
    end
    ordy = 1'b1;
    r = res;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [16:0] r;
    logic [16:0] exp;
    int          lat;
    bit          to;
    logic [15:0] ra, rb;

    vecs.push_back('{"sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0});
    vecs.push_back('{"sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1});
    vecs.push_back('{"sub_00_01", 8'h00, 8'h01, 8'hFF, 1'b1});
    vecs.push_back('{"sub_FF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0});
    vecs.push_back('{"sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{"sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0});
    vecs.push_back('{"sub_01_80", 8'h01, 8'h80, 8'h81, 1'b1});

    rst_n = 1'b0;
    sel16 = 1'b0;
    iv    = 1'b0;
    ordy  = 1'b1;
    opa   = '0;
    opb   = '0;
    #12;
    check("reset_in_ready", 32'(ir8), 32'd1);
    check("reset_out_valid", 32'(ov8), 32'd0);
    check("reset_result", 32'(res), 32'd0);
    check("reset_in_ready16", 32'(ir16), 32'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op({8'h00, vecs[i].a}, {8'h00, vecs[i].b}, 0, r, lat, to);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'd8);
      check({vecs[i].name, "_result"}, 32'(r), 32'({vecs[i].bw, vecs[i].d}));
      check({vecs[i].name, "_idle_after"}, 32'(ir8), 32'd1);
    end

    // Back-pressure: result held and no new accept while out_ready is low.
    exp  = model(16'h003C, 16'h005A, 1'b0);
    iv   = 1'b1;
    opa  = 16'h003C;
    opb  = 16'h005A;
    ordy = 1'b0;
    @(posedge clk); #1;
    iv  = 1'b0;
    check("run_in_ready", 32'(ir8), 32'd0);
    lat = 0;
    while (!ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd8);
    iv = 1'b1;
    for (int s = 0; s < 5; s++) begin
      check("bp_out_valid", 32'(ov8), 32'd1);
      check("bp_in_ready", 32'(ir8), 32'd0);
      check("bp_result", 32'(res), 32'(exp));
      @(posedge clk); #1;
    end
    iv   = 1'b0;
    ordy = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(ir8), 32'd1);
    check("bp_release_out_valid", 32'(ov8), 32'd0);

    // Reset asserted while bit 3 is being computed.
    iv  = 1'b1;
    opa = 16'h0077;
    opb = 16'h0011;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", 32'(ir8), 32'd1);
    check("rst_mid_out_valid", 32'(ov8), 32'd0);
    check("rst_mid_result", 32'(res), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h00A0, 16'h000F, 0, r, lat, to);
    check("post_rst_latency", 32'(lat), 32'd8);
    check("post_rst_result", 32'(r), 32'h091);

    for (int w = 0; w < 2; w++) begin
      sel16 = (w == 1);
      @(posedge clk); #1;
      for (int n = 0; n < 1000; n++) begin
        ra = $urandom;
        rb = $urandom;
        if (!sel16) begin
          ra[15:8] = 8'h00;
          rb[15:8] = 8'h00;
        end
        if ($urandom_range(0, 7) == 0) begin
          ra = rb;
        end
        run_op(ra, rb, $urandom_range(0, 3), r, lat, to);
        check(sel16 ? "rand16_timeout" : "rand8_timeout", 32'(to), 32'd0);
        check(sel16 ? "rand16_result" : "rand8_result", 32'(r), 32'(model(ra, rb, sel16)));
        if (n == 0) begin
          check(sel16 ? "rand16_latency" : "rand8_latency", 32'(lat), sel16 ? 32'd16 : 32'd8);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
